tfhe_hbm_rd_arb: RTL
====================

TFHE_HBM_RD_ARB -- requirements
Module: tfhe_hbm_rd_arb

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide NREQ, 4, number of read requesters (bootstrap-key fetch, ciphertext load, test-vector load, host DMA).
REQ-002 SHALL provide ADDR_W, 33, HBM byte-address width.
REQ-003 SHALL provide DATA_W, 256, HBM read-data width.
REQ-004 SHALL provide MAX_OUTST, 8, maximum outstanding bursts per requester.

Ports (name, direction, width, meaning):
REQ-005 SHALL provide aclk, in, 1, the single clock; all logic runs on its rising edge.
REQ-006 SHALL provide aresetn, in, 1, asynchronous active-low reset.
REQ-007 SHALL provide req_valid/req_ready, in/out, NREQ each, per-requester burst-request handshake.
REQ-008 SHALL provide req_addr, in, NREQ*ADDR_W, per-requester burst start address.
REQ-009 SHALL provide req_len, in, NREQ*8, per-requester AXI burst length minus one.
REQ-010 SHALL provide rsp_valid, out, NREQ, per-requester read-beat valid.
REQ-011 SHALL provide rsp_ready, in, NREQ, per-requester read-beat ready.
REQ-012 SHALL provide rsp_data, out, DATA_W, read beat shared by all requesters.
REQ-013 SHALL provide rsp_last, out, 1, last beat of the burst, shared by all requesters.
REQ-014 SHALL provide m_arvalid/m_arready, out/in, 1 each, AXI AR handshake.
REQ-015 SHALL provide m_araddr, out, ADDR_W, AXI AR address.
REQ-016 SHALL provide m_arlen, out, 8, AXI AR burst length.
REQ-017 SHALL provide m_arid, out, 2, AXI AR ID.
REQ-018 SHALL provide the AXI R channel: m_rvalid in 1, m_rready out 1, m_rdata in DATA_W, m_rid in 2, m_rlast in 1, m_rresp in 2.
REQ-019 SHALL provide err, out, NREQ, sticky per-requester error flags.
REQ-020 SHALL provide err_clr, in, 1, clears all err flags.
REQ-021 SHALL provide busy, out, 1, high while any burst is outstanding.

Function
REQ-022 AR path SHALL be a two-state FSM: IDLE (m_arvalid=0) and ISSUE (m_arvalid=1, address/length/ID registered).
REQ-023 A grant SHALL occur in IDLE, or in ISSUE in the cycle m_arready=1.
- Granted requester: the first eligible requester at or after rr_ptr, in increasing index order, wrapping to 0.
- Eligible: req_valid=1 and outstanding count < MAX_OUTST.
REQ-024 req_ready[g] SHALL be high, combinationally, only in a grant cycle and only for the granted requester; all other req_ready bits SHALL be 0.
REQ-025 On a grant, the FSM SHALL register addr/len/ID=g and go to ISSUE (m_arvalid high the next cycle); with no grant, ISSUE+m_arready SHALL return to IDLE.
REQ-026 m_araddr/m_arlen/m_arid SHALL stay stable while m_arvalid=1 and m_arready=0.
REQ-027 rr_ptr SHALL become (g+1) mod NREQ on each grant; its reset value SHALL be 0.
REQ-028 Throughput SHALL be one AR per cycle while m_arready=1 and a requester is eligible.
REQ-029 Each requester SHALL have a per-requester outstanding counter, width clog2(MAX_OUTST+1).
- Increment on grant; decrement on R handshake with m_rlast=1 for m_rid.
- Simultaneous increment and decrement of the same counter SHALL leave it unchanged.
REQ-030 R routing SHALL be combinational with zero latency:
- rsp_valid[i] = m_rvalid when m_rid=i, else 0.
- m_rready = rsp_ready[m_rid].
- rsp_data = m_rdata; rsp_last = m_rlast.
REQ-031 An R handshake with m_rresp != 0 SHALL set err[m_rid] the next cycle.
REQ-032 err_clr SHALL clear all err bits; a simultaneous set SHALL take priority over err_clr.
REQ-033 An R beat whose m_rid has an outstanding count of 0 SHALL set err[m_rid] and SHALL NOT underflow the counter.
REQ-034 busy SHALL be the OR of (counter != 0) over all requesters, OR m_arvalid.

Reset
REQ-035 aresetn low SHALL asynchronously force the following, including mid-burst:
- FSM to IDLE, m_arvalid=0, rr_ptr=0.
- All outstanding counters and err flags to 0.
- m_araddr/m_arlen/m_arid to 0.
REQ-036 While aresetn is low, req_ready SHALL be 0.
REQ-037 The HBM controller SHALL be reset together with this block; R beats that arrive after reset for pre-reset bursts SHALL be flagged per REQ-033.

Structure
REQ-038 A shared package tfhe_pu_pkg SHALL hold the HBM_ADDR_W, HBM_DATA_W and requester-index constants (REQ_BSK=0, REQ_CT=1, REQ_TV=2, REQ_HOST=3).
REQ-039 The round-robin selector SHALL be a sub-module tfhe_rr_sel, parameterised by N: inputs eligible vector and rr_ptr; outputs grant-valid and grant index.

Verification
REQ-040 Single request: req_valid[1]=1, addr 0x1000, len 7, m_arready=1.
- Expected: req_ready[1] in cycle 0.
- Expected: m_arvalid, araddr=0x1000, arlen=7, arid=1 in cycle 1.
- After 8 R beats with id 1: busy=0.
REQ-041 Fairness: all four req_valid held high, m_arready=1.
- Expected: arid sequence 0,1,2,3,0,1, back-to-back at one AR per cycle.
REQ-042 Backpressure: m_arready=0 for 5 cycles.
- Expected: AR fields stable, no further req_ready, exactly one grant when m_arready rises.
REQ-043 Outstanding limit: requester 2 issues 8 bursts with no R traffic.
- Expected: ninth request stalls; other requesters are still granted.
- After one rlast with id 2: the stalled request is granted.
REQ-044 Error and reset paths:
- m_rresp=2 on an id 3 beat: err[3]=1 next cycle, held until err_clr.
- aresetn low mid-burst: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/tfhe_pu_pkg.sv
// Shared constants and types for the TFHE processing unit.
// HBM widths, requester indices and the AR-path FSM states.
package tfhe_pu_pkg;

  localparam int HBM_ADDR_W = 33;
  localparam int HBM_DATA_W = 256;
  localparam int HBM_ID_W   = 2;

  localparam int REQ_BSK  = 0;
  localparam int REQ_CT   = 1;
  localparam int REQ_TV   = 2;
  localparam int REQ_HOST = 3;
  localparam int NUM_REQ  = 4;

  typedef enum logic {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

endpackage

// File: rtl/tfhe_rr_sel.sv
// Round-robin selector: first eligible index at or after ptr, wrapping.
// Ports: elig (eligible vector), ptr (start index), gnt_vld, gnt_idx.
module tfhe_rr_sel #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j       = 0;
    jj      = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk from the far end back to ptr so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (elig[jj]) begin
        gnt_vld = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/tfhe_hbm_rd_arb.sv
// HBM read arbiter: round-robin AR issue for NREQ requesters, R routing by ID.
// Ports: req_* burst requests, rsp_* routed beats, m_ar*/m_r* AXI, err, busy.
module tfhe_hbm_rd_arb
  import tfhe_pu_pkg::*;
#(
  parameter  int NREQ      = NUM_REQ,
  parameter  int ADDR_W    = HBM_ADDR_W,
  parameter  int DATA_W    = HBM_DATA_W,
  parameter  int MAX_OUTST = 8,
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW        = $clog2(MAX_OUTST + 1)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*8-1:0]      req_len,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_last,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  output logic [ADDR_W-1:0]      m_araddr,
  output logic [7:0]             m_arlen,
  output logic [1:0]             m_arid,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic [DATA_W-1:0]      m_rdata,
  input  logic [1:0]             m_rid,
  input  logic                   m_rlast,
  input  logic [1:0]             m_rresp,
  output logic [NREQ-1:0]        err,
  input  logic                   err_clr,
  output logic                   busy
);

  ar_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [1:0]        id_q, id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q [NREQ];
  logic [CW-1:0]     cnt_d [NREQ];
  logic [NREQ-1:0]   err_q, err_d;

  logic [NREQ-1:0]   elig;
  logic              gnt_vld;
  logic [IW-1:0]     gnt_idx;
  logic              gnt;
  logic              r_hs;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (cnt_q[i] < CW'(MAX_OUTST));
    end
  end

  tfhe_rr_sel #(.N(NREQ)) u_sel (
    .elig    (elig),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // A slot opens when the AR register is empty or being drained.
  // aresetn gating keeps req_ready low while reset is held.
  assign gnt = aresetn && gnt_vld &&
               ((state_q == AR_IDLE) || m_arready);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt && (gnt_idx == IW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (gnt) begin
      state_d = AR_ISSUE;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_idx == IW'(i)) begin
          addr_d = req_addr[i*ADDR_W +: ADDR_W];
          len_d  = req_len[i*8 +: 8];
        end
      end
      id_d  = 2'(gnt_idx);
      ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if ((state_q == AR_ISSUE) && m_arready) begin
      state_d = AR_IDLE;
    end
  end

  always_comb begin
    m_rready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = m_rvalid && (m_rid == 2'(i));
      if (m_rid == 2'(i)) m_rready = rsp_ready[i];
    end
  end

  assign rsp_data = m_rdata;
  assign rsp_last = m_rlast;
  assign r_hs     = m_rvalid && m_rready;

  // A beat for an ID with nothing outstanding is flagged and never
  // decrements, so stale beats after reset cannot wrap the counter.
  always_comb begin
    logic inc, dec, hit;
    inc   = 1'b0;
    dec   = 1'b0;
    hit   = 1'b0;
    err_d = err_clr ? '0 : err_q;
    for (int i = 0; i < NREQ; i++) begin
      hit = r_hs && (m_rid == 2'(i));
      inc = gnt && (gnt_idx == IW'(i));
      dec = hit && m_rlast && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) cnt_d[i] = cnt_q[i] + 1'b1;
      if (dec && !inc) cnt_d[i] = cnt_q[i] - 1'b1;
      if (hit && ((m_rresp != 2'b00) || (cnt_q[i] == '0))) begin
        err_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= AR_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign m_arvalid = (state_q == AR_ISSUE);
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arid    = id_q;
  assign err       = err_q;

  always_comb begin
    busy = m_arvalid;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

endmodule
